add_accum: RTL

- Streaming accumulator placed directly downstream of the 8-bit ripple-carry adder stage.
- Consumes a packet of operand beats over a valid/ready handshake and adds them one per cycle: acc + in_data, WIDTH-bit sum plus carry-out.
- Counts carry-outs and beats, then presents the packet total on a registered, single-entry output with its own valid/ready handshake.
- True total = out_carry * 2^WIDTH + out_sum.

---
 rtl/add_accum.sv | 71 +++++++
 1 files changed

// File: rtl/add_accum.sv
// add_accum: streaming packet accumulator with carry/beat counters and a registered result slot.
module add_accum #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_carry,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;
  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_carry, r_beat;
  logic             r_ovf;
  logic             w_fire, w_emit, w_ovf_nx, w_busy;
  logic [WIDTH:0]   w_add;
  logic [CNT_W-1:0] w_carry, w_beat, w_carry_nx, w_beat_nx;
  assign in_ready = !out_valid | out_ready;
  assign w_fire   = in_valid & in_ready;
  assign w_emit   = w_fire & in_last;
  // IDLE means a fresh packet, so the running values are taken as zero there.
  assign w_busy     = r_state == ACCUM;
  assign w_carry    = w_busy ? r_carry : '0;
  assign w_beat     = w_busy ? r_beat : '0;
  assign w_add      = {1'b0, (w_busy ? r_acc : WIDTH'(0))} + {1'b0, in_data};
  assign w_carry_nx = (w_add[WIDTH] && !(&w_carry)) ? w_carry + CNT_W'(1) : w_carry;
  assign w_beat_nx  = (&w_beat) ? w_beat : w_beat + CNT_W'(1);
  assign w_ovf_nx   = (w_busy & r_ovf) | (w_add[WIDTH] & (&w_carry)) | (&w_beat);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_carry <= '0;
      r_beat  <= '0;
      r_ovf   <= 1'b0;
    end else if (w_fire) begin
      r_state <= in_last ? IDLE : ACCUM;
      r_acc   <= in_last ? '0 : w_add[WIDTH-1:0];
      r_carry <= in_last ? '0 : w_carry_nx;
      r_beat  <= in_last ? '0 : w_beat_nx;
      r_ovf   <= in_last ? 1'b0 : w_ovf_nx;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_carry <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (w_emit) begin
      out_valid <= 1'b1;
      out_sum   <= w_add[WIDTH-1:0];
      out_carry <= w_carry_nx;
      out_count <= w_beat_nx;
      out_ovf   <= w_ovf_nx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
